// File: rtl/mem_access_sequencer_if.sv
// Memory/control bundle between the sequencer and the surrounding RV32I datapath.
// Carries the instruction word, the memory handshake and every sequencer control output.
// master = sequencer side, slave = datapath/memory side.
interface mem_access_sequencer_if #(
  parameter int CNT_W = 32
);
  logic [31:0]      INSN;
  logic             mem_ready;
  logic [1:0]       addr_lsb;
  logic             mem_req;
  logic             mem_we;
  logic [1:0]       mem_size;
  logic             addr_sel;
  logic             ir_load;
  logic             pc_we;
  logic             rd_we;
  logic             retire;
  logic [CNT_W-1:0] retired_cnt;
  logic             busy;
  logic             fault;
  logic [1:0]       fault_code;

  modport master (
    input  INSN, mem_ready, addr_lsb,
    output mem_req, mem_we, mem_size, addr_sel, ir_load, pc_we, rd_we,
           retire, retired_cnt, busy, fault, fault_code
  );

  modport slave (
    output INSN, mem_ready, addr_lsb,
    input  mem_req, mem_we, mem_size, addr_sel, ir_load, pc_we, rd_we,
           retire, retired_cnt, busy, fault, fault_code
  );
endinterface

// File: rtl/mem_access_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer sharing one memory port between fetch and data.
// Latency (zero-wait memory): BRANCH 3, ALU-class 4, STORE 4, LOAD 5 cycles per instruction.
// Memory request held stable until mem_ready; a request waiting TIMEOUT cycles faults (sticky).
module mem_access_sequencer #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input logic                    CLK,
  input logic                    RESET,
  mem_access_sequencer_if.master bus
);

  localparam logic [2:0] ST_RST    = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_DECODE = 3'd2;
  localparam logic [2:0] ST_EXEC   = 3'd3;
  localparam logic [2:0] ST_MEM    = 3'd4;
  localparam logic [2:0] ST_WB     = 3'd5;
  localparam logic [2:0] ST_FAULT  = 3'd6;

  localparam logic [1:0] FC_NONE     = 2'b00;
  localparam logic [1:0] FC_ILLEGAL  = 2'b01;
  localparam logic [1:0] FC_MISALIGN = 2'b10;
  localparam logic [1:0] FC_TIMEOUT  = 2'b11;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  logic [2:0]       state_q, state_d;
  logic [1:0]       code_q, code_d;
  logic [7:0]       wait_q, wait_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       is_load, is_store, is_branch, is_alu;
  logic       illegal, misaligned, wait_expired;
  logic       retire_c;

  // Only opcode and funct3 steer the timing; the rest of the word belongs to the datapath.
  logic unused_insn_bits;
  assign unused_insn_bits = ^{bus.INSN[31:15], bus.INSN[11:7]};

  assign opcode = bus.INSN[6:0];
  assign funct3 = bus.INSN[14:12];

  // Instruction classification and legality/alignment checks.
  always_comb begin
    is_load   = (opcode == 7'b0000011);
    is_store  = (opcode == 7'b0100011);
    is_branch = (opcode == 7'b1100011);
    is_alu    = (opcode == 7'b0010011) || (opcode == 7'b0110011) ||
                (opcode == 7'b0110111) || (opcode == 7'b0010111) ||
                (opcode == 7'b1101111) || (opcode == 7'b1100111);
    illegal   = !(is_load || is_store || is_branch || is_alu) ||
                (is_load  && (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111)) ||
                (is_store && (funct3[2] || funct3 == 3'b011));
    // funct3[1:0] is the access size for both signed and unsigned loads.
    misaligned = ((funct3[1:0] == 2'b01) && bus.addr_lsb[0]) ||
                 ((funct3[1:0] == 2'b10) && (bus.addr_lsb != 2'b00));
    // A ready on the last allowed cycle still completes the request.
    wait_expired = !bus.mem_ready && (wait_q == WAIT_LAST);
  end

  // Next-state, fault-code and wait-counter logic.
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    case (state_q)
      ST_RST:    state_d = ST_FETCH;
      ST_FETCH: begin
        if (bus.mem_ready) begin
          state_d = ST_DECODE;
        end else if (wait_expired) begin
          state_d = ST_FAULT;
          code_d  = FC_TIMEOUT;
        end
      end
      ST_DECODE: begin
        if (illegal) begin
          state_d = ST_FAULT;
          code_d  = FC_ILLEGAL;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (is_load || is_store) begin
          if (misaligned) begin
            state_d = ST_FAULT;
            code_d  = FC_MISALIGN;
          end else begin
            state_d = ST_MEM;
          end
        end else if (is_branch) begin
          state_d = ST_FETCH;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        if (bus.mem_ready) begin
          state_d = is_store ? ST_FETCH : ST_WB;
        end else if (wait_expired) begin
          state_d = ST_FAULT;
          code_d  = FC_TIMEOUT;
        end
      end
      ST_WB:     state_d = ST_FETCH;
      ST_FAULT:  state_d = ST_FAULT;
      default: begin
        state_d = ST_FAULT;
        code_d  = FC_ILLEGAL;
      end
    endcase

    // Any state change restarts the wait count, so FETCH and MEM always start from zero.
    if (state_d != state_q) begin
      wait_d = 8'd0;
    end else if ((state_q == ST_FETCH || state_q == ST_MEM) && !bus.mem_ready) begin
      wait_d = wait_q + 8'd1;
    end else begin
      wait_d = wait_q;
    end
  end

  // Moore-decoded controls; ir_load, pc_we and retire also qualify on mem_ready where needed.
  always_comb begin
    bus.mem_req  = 1'b0;
    bus.mem_we   = 1'b0;
    bus.mem_size = 2'b00;
    bus.addr_sel = 1'b0;
    bus.ir_load  = 1'b0;
    bus.pc_we    = 1'b0;
    bus.rd_we    = 1'b0;
    retire_c     = 1'b0;
    case (state_q)
      ST_FETCH: begin
        bus.mem_req  = 1'b1;
        bus.mem_size = 2'b10;
        bus.ir_load  = bus.mem_ready;
      end
      ST_EXEC: begin
        bus.pc_we = is_branch;
        retire_c  = is_branch;
      end
      ST_MEM: begin
        bus.mem_req  = 1'b1;
        bus.addr_sel = 1'b1;
        bus.mem_we   = is_store;
        bus.mem_size = funct3[1:0];
        bus.pc_we    = is_store && bus.mem_ready;
        retire_c     = is_store && bus.mem_ready;
      end
      ST_WB: begin
        bus.rd_we = 1'b1;
        bus.pc_we = 1'b1;
        retire_c  = 1'b1;
      end
      default: ;
    endcase
    bus.retire     = retire_c;
    bus.busy       = (state_q != ST_RST) && (state_q != ST_FAULT);
    bus.fault      = (state_q == ST_FAULT);
    bus.fault_code = code_q;
    cnt_d          = cnt_q + CNT_W'(retire_c);
  end

  assign bus.retired_cnt = cnt_q;

  // State registers; reset drops any pending request immediately.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_RST;
      code_q  <= FC_NONE;
      wait_q  <= 8'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      wait_q  <= wait_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Scoreboard bench for mem_access_sequencer: per-cycle stimulus and expected outputs are queued
// by each scenario, then replayed one cycle at a time and compared at negedge+1.
// Output vector order: {req, we, size[1:0], addr_sel, ir_load, pc_we, rd_we, retire, busy, fault, code[1:0]}.
module tb_mem_access_sequencer;

  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  mem_access_sequencer_if #(.CNT_W(32)) bus ();

  mem_access_sequencer #(.TIMEOUT(16), .CNT_W(32)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  typedef struct {
    logic        rst;
    logic [31:0] insn;
    logic [1:0]  lsb;
    logic        rdy;
    logic [12:0] o;
    logic [31:0] cnt;
  } step_t;

  step_t       sbq[$];
  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] model_cnt = 0;

  localparam logic [31:0] LW   = 32'h0087A803;
  localparam logic [31:0] SW   = 32'h00F7A423;
  localparam logic [31:0] BEQ  = 32'h00000063;
  localparam logic [31:0] ADDI = 32'h00100093;
  localparam logic [31:0] LH   = 32'h00001003;
  localparam logic [31:0] LW3  = 32'h00003003;
  localparam logic [31:0] ILL  = 32'h00000000;

  localparam logic [12:0] ZERO     = 13'b0_0_00_0_0_0_0_0_0_0_00;
  localparam logic [12:0] F_RDY    = 13'b1_0_10_0_1_0_0_0_1_0_00;
  localparam logic [12:0] F_WAIT   = 13'b1_0_10_0_0_0_0_0_1_0_00;
  localparam logic [12:0] IDLE     = 13'b0_0_00_0_0_0_0_0_1_0_00;
  localparam logic [12:0] EX_BR    = 13'b0_0_00_0_0_1_0_1_1_0_00;
  localparam logic [12:0] MEM_LW   = 13'b1_0_10_1_0_0_0_0_1_0_00;
  localparam logic [12:0] MEM_SW_W = 13'b1_1_10_1_0_0_0_0_1_0_00;
  localparam logic [12:0] MEM_SW_R = 13'b1_1_10_1_0_1_0_1_1_0_00;
  localparam logic [12:0] WB       = 13'b0_0_00_0_0_1_1_1_1_0_00;
  localparam logic [12:0] FLT01    = 13'b0_0_00_0_0_0_0_0_0_1_01;
  localparam logic [12:0] FLT10    = 13'b0_0_00_0_0_0_0_0_0_1_10;
  localparam logic [12:0] FLT11    = 13'b0_0_00_0_0_0_0_0_0_1_11;

  function automatic logic [12:0] obs();
    return {bus.mem_req, bus.mem_we, bus.mem_size, bus.addr_sel, bus.ir_load, bus.pc_we,
            bus.rd_we, bus.retire, bus.busy, bus.fault, bus.fault_code};
  endfunction

  // Queue one cycle: stimulus plus expected outputs; retired count tracks expected retires.
  task automatic push(input logic rst, input logic [31:0] insn, input logic [1:0] lsb,
                      input logic rdy, input logic [12:0] o);
    step_t s;
    if (rst) model_cnt = 0;
    s.rst = rst; s.insn = insn; s.lsb = lsb; s.rdy = rdy; s.o = o; s.cnt = model_cnt;
    if (o[4]) model_cnt = model_cnt + 1;
    sbq.push_back(s);
  endtask

  // Reset pulse: one cycle asserted, one cycle released but still before the first edge.
  task automatic push_reset();
    push(1'b1, ILL, 2'b00, 1'b0, ZERO);
    push(1'b0, ILL, 2'b00, 1'b0, ZERO);
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    bus.INSN = ILL; bus.addr_lsb = 2'b00; bus.mem_ready = 1'b1;
    @(negedge CLK); @(negedge CLK); #1;
    n_chk++;
    if (obs() !== ZERO) begin
      n_fail++; $display("FAIL reset_outputs got=%b want=%b", obs(), ZERO);
    end
    n_chk++;
    if (bus.retired_cnt !== 32'd0) begin
      n_fail++; $display("FAIL reset_cnt got=%0d want=0", bus.retired_cnt);
    end
    RESET = 1'b0;
  endtask

  task automatic test_load();
    step_t s;
    int c = 0;
    push(0, LW, 2'b00, 1, F_RDY); push(0, LW, 2'b00, 1, IDLE); push(0, LW, 2'b00, 1, IDLE);
    push(0, LW, 2'b00, 1, MEM_LW); push(0, LW, 2'b00, 1, WB);
    while (sbq.size() != 0) begin
      s = sbq.pop_front();
      @(negedge CLK); RESET = s.rst; bus.INSN = s.insn; bus.addr_lsb = s.lsb; bus.mem_ready = s.rdy; #1;
      n_chk++;
      if (obs() !== s.o || bus.retired_cnt !== s.cnt) begin
        n_fail++; $display("FAIL load cyc%0d got=%b cnt=%0d want=%b cnt=%0d", c, obs(), bus.retired_cnt, s.o, s.cnt);
      end
      c++;
    end
  endtask

  task automatic test_store();
    step_t s;
    int c = 0;
    push(0, SW, 2'b00, 1, F_RDY); push(0, SW, 2'b00, 1, IDLE); push(0, SW, 2'b00, 1, IDLE);
    for (int i = 0; i < 3; i++) push(0, SW, 2'b00, 0, MEM_SW_W);
    push(0, SW, 2'b00, 1, MEM_SW_R);
    while (sbq.size() != 0) begin
      s = sbq.pop_front();
      @(negedge CLK); RESET = s.rst; bus.INSN = s.insn; bus.addr_lsb = s.lsb; bus.mem_ready = s.rdy; #1;
      n_chk++;
      if (obs() !== s.o || bus.retired_cnt !== s.cnt) begin
        n_fail++; $display("FAIL store cyc%0d got=%b cnt=%0d want=%b cnt=%0d", c, obs(), bus.retired_cnt, s.o, s.cnt);
      end
      c++;
    end
  endtask

  task automatic test_back_to_back();
    step_t s;
    int c = 0;
    push(0, BEQ, 2'b00, 1, F_RDY); push(0, BEQ, 2'b00, 1, IDLE); push(0, BEQ, 2'b00, 1, EX_BR);
    push(0, ADDI, 2'b00, 1, F_RDY); push(0, ADDI, 2'b00, 1, IDLE); push(0, ADDI, 2'b00, 1, IDLE);
    push(0, ADDI, 2'b00, 1, WB);
    push(0, LW, 2'b00, 1, F_RDY); push(0, LW, 2'b00, 1, IDLE); push(0, LW, 2'b00, 1, IDLE);
    push(0, LW, 2'b00, 1, MEM_LW); push(0, LW, 2'b00, 1, WB);
    while (sbq.size() != 0) begin
      s = sbq.pop_front();
      @(negedge CLK); RESET = s.rst; bus.INSN = s.insn; bus.addr_lsb = s.lsb; bus.mem_ready = s.rdy; #1;
      n_chk++;
      if (obs() !== s.o || bus.retired_cnt !== s.cnt) begin
        n_fail++; $display("FAIL b2b cyc%0d got=%b cnt=%0d want=%b cnt=%0d", c, obs(), bus.retired_cnt, s.o, s.cnt);
      end
      c++;
    end
  endtask

  task automatic test_ready_wins();
    step_t s;
    int c = 0;
    for (int i = 0; i < 15; i++) push(0, ADDI, 2'b00, 0, F_WAIT);
    push(0, ADDI, 2'b00, 1, F_RDY); push(0, ADDI, 2'b00, 1, IDLE); push(0, ADDI, 2'b00, 1, IDLE);
    push(0, ADDI, 2'b00, 1, WB);
    while (sbq.size() != 0) begin
      s = sbq.pop_front();
      @(negedge CLK); RESET = s.rst; bus.INSN = s.insn; bus.addr_lsb = s.lsb; bus.mem_ready = s.rdy; #1;
      n_chk++;
      if (obs() !== s.o || bus.retired_cnt !== s.cnt) begin
        n_fail++; $display("FAIL ready_wins cyc%0d got=%b cnt=%0d want=%b cnt=%0d", c, obs(), bus.retired_cnt, s.o, s.cnt);
      end
      c++;
    end
  endtask

  task automatic test_misaligned();
    step_t s;
    int c = 0;
    push(0, LH, 2'b01, 1, F_RDY); push(0, LH, 2'b01, 1, IDLE); push(0, LH, 2'b01, 1, IDLE);
    for (int i = 0; i < 3; i++) push(0, LH, 2'b01, 1, FLT10);
    push_reset();
    push(0, ADDI, 2'b00, 1, F_RDY); push(0, ADDI, 2'b00, 1, IDLE); push(0, ADDI, 2'b00, 1, IDLE);
    push(0, ADDI, 2'b00, 1, WB);
    while (sbq.size() != 0) begin
      s = sbq.pop_front();
      @(negedge CLK); RESET = s.rst; bus.INSN = s.insn; bus.addr_lsb = s.lsb; bus.mem_ready = s.rdy; #1;
      n_chk++;
      if (obs() !== s.o || bus.retired_cnt !== s.cnt) begin
        n_fail++; $display("FAIL misaligned cyc%0d got=%b cnt=%0d want=%b cnt=%0d", c, obs(), bus.retired_cnt, s.o, s.cnt);
      end
      c++;
    end
  endtask

  task automatic test_illegal();
    step_t s;
    int c = 0;
    push(0, ILL, 2'b00, 1, F_RDY); push(0, ILL, 2'b00, 1, IDLE);
    push(0, ILL, 2'b00, 1, FLT01); push(0, ILL, 2'b00, 1, FLT01);
    push_reset();
    push(0, LW3, 2'b00, 1, F_RDY); push(0, LW3, 2'b00, 1, IDLE); push(0, LW3, 2'b00, 1, FLT01);
    push_reset();
    push(0, SW | 32'h00004000, 2'b00, 1, F_RDY); push(0, SW | 32'h00004000, 2'b00, 1, IDLE);
    push(0, SW | 32'h00004000, 2'b00, 1, FLT01);
    push_reset();
    while (sbq.size() != 0) begin
      s = sbq.pop_front();
      @(negedge CLK); RESET = s.rst; bus.INSN = s.insn; bus.addr_lsb = s.lsb; bus.mem_ready = s.rdy; #1;
      n_chk++;
      if (obs() !== s.o || bus.retired_cnt !== s.cnt) begin
        n_fail++; $display("FAIL illegal cyc%0d got=%b cnt=%0d want=%b cnt=%0d", c, obs(), bus.retired_cnt, s.o, s.cnt);
      end
      c++;
    end
  endtask

  task automatic test_timeout();
    step_t s;
    int c = 0;
    for (int i = 0; i < 16; i++) push(0, ADDI, 2'b00, 0, F_WAIT);
    push(0, ADDI, 2'b00, 1, FLT11); push(0, ADDI, 2'b00, 1, FLT11);
    push_reset();
    while (sbq.size() != 0) begin
      s = sbq.pop_front();
      @(negedge CLK); RESET = s.rst; bus.INSN = s.insn; bus.addr_lsb = s.lsb; bus.mem_ready = s.rdy; #1;
      n_chk++;
      if (obs() !== s.o || bus.retired_cnt !== s.cnt) begin
        n_fail++; $display("FAIL timeout cyc%0d got=%b cnt=%0d want=%b cnt=%0d", c, obs(), bus.retired_cnt, s.o, s.cnt);
      end
      c++;
    end
  endtask

  task automatic test_reset_mid();
    step_t s;
    int c = 0;
    push(0, BEQ, 2'b00, 1, F_RDY); push(0, BEQ, 2'b00, 1, IDLE); push(0, BEQ, 2'b00, 1, EX_BR);
    push(0, SW, 2'b00, 1, F_RDY); push(0, SW, 2'b00, 1, IDLE); push(0, SW, 2'b00, 1, IDLE);
    push(0, SW, 2'b00, 0, MEM_SW_W); push(0, SW, 2'b00, 0, MEM_SW_W);
    while (sbq.size() != 0) begin
      s = sbq.pop_front();
      @(negedge CLK); RESET = s.rst; bus.INSN = s.insn; bus.addr_lsb = s.lsb; bus.mem_ready = s.rdy; #1;
      n_chk++;
      if (obs() !== s.o || bus.retired_cnt !== s.cnt) begin
        n_fail++; $display("FAIL reset_mid cyc%0d got=%b cnt=%0d want=%b cnt=%0d", c, obs(), bus.retired_cnt, s.o, s.cnt);
      end
      c++;
    end
    // Assert reset between clock edges while MEM is still waiting.
    #2 RESET = 1'b1;
    #1;
    n_chk++;
    if (bus.mem_req !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_req got=%b want=0", bus.mem_req);
    end
    n_chk++;
    if (obs() !== ZERO || bus.retired_cnt !== 32'd0) begin
      n_fail++; $display("FAIL reset_mid_outs got=%b cnt=%0d want=%b cnt=0", obs(), bus.retired_cnt, ZERO);
    end
    @(negedge CLK); RESET = 1'b0; model_cnt = 0;
    c = 0;
    push(0, ADDI, 2'b00, 1, F_RDY); push(0, ADDI, 2'b00, 1, IDLE); push(0, ADDI, 2'b00, 1, IDLE);
    push(0, ADDI, 2'b00, 1, WB); push(0, ADDI, 2'b00, 0, F_WAIT);
    while (sbq.size() != 0) begin
      s = sbq.pop_front();
      @(negedge CLK); RESET = s.rst; bus.INSN = s.insn; bus.addr_lsb = s.lsb; bus.mem_ready = s.rdy; #1;
      n_chk++;
      if (obs() !== s.o || bus.retired_cnt !== s.cnt) begin
        n_fail++; $display("FAIL reset_mid_restart cyc%0d got=%b cnt=%0d want=%b cnt=%0d", c, obs(), bus.retired_cnt, s.o, s.cnt);
      end
      c++;
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_store();
    test_back_to_back();
    test_ready_wins();
    test_misaligned();
    test_illegal();
    test_timeout();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_sequencer.md
Name: mem_access_sequencer

Overview:
- Multi-cycle control sequencer for the RV32I core. Shares the single memory port between instruction fetch and load/store data access.
- Steps each instruction through FETCH, DECODE, EXEC, MEM and WB. Drives the address mux, the IR/PC/register-file write enables and the memory request handshake.
- Sits in the Control_Unit beside the instruction-type decoders. The decoders supply ALU/mux controls; this block supplies the timing.

Parameters:
TIMEOUT, 16, max cycles a memory request may wait for mem_ready before FAULT (2..255)
CNT_W, 32, width of retired-instruction counter

Ports:
CLK  in  1  system clock, rising-edge
RESET  in  1  asynchronous, active-high reset
INSN  in  32  instruction register contents (valid from DECODE onward)
mem_ready  in  1  memory completes current request this cycle
addr_lsb  in  2  ALU result bits [1:0] (effective address), valid in EXEC
mem_req  out  1  memory request active
mem_we  out  1  1 = store, 0 = read
mem_size  out  2  00 byte, 01 half, 10 word
addr_sel  out  1  memory address mux: 0 = PC, 1 = ALU result
ir_load  out  1  capture memory read data into IR
pc_we  out  1  PC register update enable
rd_we  out  1  register-file rd write enable
retire  out  1  one-cycle pulse per completed instruction
retired_cnt  out  CNT_W  count of retired instructions
busy  out  1  1 in every state except RST and FAULT
fault  out  1  sticky fault flag
fault_code  out  2  00 none, 01 illegal opcode/funct3, 10 misaligned, 11 memory timeout

Behaviour:
- Reset:
  - While RESET is high, state = RST and retired_cnt = 0.
  - All outputs are 0 while RESET is high.
  - The first rising edge after RESET falls moves to FETCH.
  - RESET asserted mid-operation aborts immediately; any pending memory request is dropped (mem_req goes to 0 asynchronously).
- Output timing: state register plus Moore-decoded outputs. retire, pc_we, rd_we and ir_load are combinational from state and mem_ready where noted below.
- FETCH:
  - mem_req=1, addr_sel=0, mem_we=0, mem_size=10.
  - On an edge with mem_ready=1: ir_load=1 during that cycle; next state DECODE.
- DECODE:
  - Classify INSN[6:0] as LOAD 0000011, STORE 0100011, BRANCH 1100011, or ALU-class (0010011, 0110011, 0110111, 0010111, 1101111, 1100111).
  - Any other opcode goes to FAULT with code 01.
  - LOAD funct3 in {011, 110, 111} goes to FAULT code 01.
  - STORE funct3[2]=1 or funct3=011 goes to FAULT code 01.
  - Otherwise next state EXEC.
- EXEC:
  - ALU evaluates (one cycle).
  - LOAD/STORE: alignment check on addr_lsb. Half with addr_lsb[0]=1 is misaligned; word with addr_lsb≠00 is misaligned. Misaligned goes to FAULT code 10, otherwise MEM.
  - BRANCH: pc_we=1, retire=1, next FETCH.
  - ALU-class: next WB.
- MEM:
  - mem_req=1, addr_sel=1, mem_size=funct3[1:0], mem_we=1 for STORE.
  - On mem_ready, LOAD goes to WB.
  - On mem_ready, STORE asserts pc_we=1 and retire=1 that cycle and goes to FETCH.
- WB: rd_we=1, pc_we=1, retire=1; next FETCH.
- Latency with zero-wait memory:
  - ALU-class: 4 cycles.
  - LOAD: 5 cycles.
  - STORE: 4 cycles.
  - BRANCH: 3 cycles.
- Retired counter: retired_cnt increments on every cycle where retire=1. It wraps from 2^CNT_W−1 to 0.
- Timeout:
  - The wait counter clears on entry to FETCH/MEM and increments each cycle mem_ready=0.
  - If it reaches TIMEOUT−1 with mem_ready still 0, go to FAULT code 11.
  - If mem_ready=1 on that same cycle, ready wins and there is no fault.
- FAULT: sticky; all enables 0, fault=1, busy=0. Exit only via RESET.
- Handshake: mem_req, mem_we, mem_size and addr_sel are held stable until the cycle mem_ready is sampled high. mem_ready is ignored when mem_req=0.

Test Plan:
- Reset, then INSN=32'h0087A803 (lw x16, 8(x15)), addr_lsb=00, mem_ready tied 1 → states FETCH, DECODE, EXEC, MEM (addr_sel=1, mem_size=10, mem_we=0), WB (rd_we=1, pc_we=1). retire pulses once at cycle 5; retired_cnt=1.
- Store 32'h00F7A423 (sw x15, 8(x15)), mem_ready delayed 3 cycles in MEM → mem_req, mem_we=1, addr_sel=1 held stable 4 cycles. pc_we=1 and retire=1 on the ready cycle; next state FETCH; rd_we never 1.
- lh (funct3=001) with addr_lsb=01 → FAULT after EXEC with fault_code=10 and mem_req never asserted for data. Subsequent edges hold fault=1 until RESET pulse, then busy=1 and FETCH resumes.
- Opcode 0000000 → FAULT code 01 at end of DECODE. lw with funct3=011 → FAULT code 01.
- FETCH with mem_ready held 0, TIMEOUT=16 → FAULT code 11 after exactly 16 FETCH cycles. Repeat with mem_ready=1 on the 16th cycle → no fault, ir_load=1.
- RESET asserted during MEM wait → mem_req drops to 0 asynchronously. Outputs return to 0, retired_cnt=0, restart in FETCH after release.
